// File: rtl/frame_uart_sender.sv
// frame_uart_sender: streams a WIDTH x HEIGHT pixel frame, preceded by a sync/size header, to a byte UART.
// Define FRAME_CHECKSUM_EN to append a 16-bit sum of all pixel bytes as a two-byte trailer.
module frame_uart_sender #(
   parameter int         WIDTH     = 640,
   parameter int         HEIGHT    = 480,
   parameter int         CHANNELS  = 3,
   parameter int         CH_BITS   = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [CHANNELS*CH_BITS-1:0]  pix_data,
   input  logic                         pix_valid,
   output logic                         pix_ready,
   output logic [7:0]                   tx_data,
   output logic                         tx_start,
   input  logic                         tx_busy,
   output logic                         busy,
   output logic                         done,
   output logic [15:0]                  x_pos,
   output logic [15:0]                  y_pos
);
   localparam int         PW      = CHANNELS * CH_BITS;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HDR     = 3'd1;
   localparam logic [2:0] FETCH   = 3'd2;
   localparam logic [2:0] SEND    = 3'd3;
   localparam logic [2:0] WAIT_HI = 3'd4;
   localparam logic [2:0] WAIT_LO = 3'd5;
   localparam logic [2:0] DONE    = 3'd7;
   localparam logic [1:0] PH_HDR  = 2'd0;
   localparam logic [1:0] PH_PIX  = 2'd1;
   localparam logic [15:0] W16    = 16'(WIDTH);
   localparam logic [15:0] H16    = 16'(HEIGHT);
`ifdef FRAME_CHECKSUM_EN
   localparam logic [2:0] TRAILER = 3'd6;
   localparam logic [1:0] PH_TRL  = 2'd2;
   logic [15:0] sum_q, sum_d;
`endif

   logic [2:0]         state_q, state_d, idx_q, idx_d;
   logic [1:0]         phase_q, phase_d;
   logic [15:0]        x_q, x_d, y_q, y_d;
   logic [PW-1:0]      pix_q, pix_d;
   logic [CH_BITS-1:0] ch;
   logic [7:0]         hdr_byte, pix_byte, byte_out;
   logic               last_ch, last_col, last_pix;

   // The byte on the wire is derived from phase/index, so it is stable from SEND through WAIT_LO.
   assign hdr_byte = idx_q == 3'd0 ? SYNC_BYTE :
                     idx_q == 3'd1 ? W16[15:8] :
                     idx_q == 3'd2 ? W16[7:0]  :
                     idx_q == 3'd3 ? H16[15:8] : H16[7:0];
   assign ch       = pix_q[idx_q*CH_BITS +: CH_BITS];
   assign pix_byte = 8'(ch) << (8 - CH_BITS);
`ifdef FRAME_CHECKSUM_EN
   assign byte_out = phase_q == PH_PIX ? pix_byte :
                     phase_q == PH_TRL ? (idx_q == 3'd0 ? sum_q[15:8] : sum_q[7:0]) : hdr_byte;
`else
   assign byte_out = phase_q == PH_PIX ? pix_byte : hdr_byte;
`endif

   assign last_ch   = idx_q == 3'(CHANNELS - 1);
   assign last_col  = x_q == W16 - 16'd1;
   assign last_pix  = last_col && y_q == H16 - 16'd1;
   assign busy      = state_q != IDLE && state_q != DONE;
   assign done      = state_q == DONE;
   assign pix_ready = state_q == FETCH && !abort;
   assign tx_start  = state_q == SEND && !abort;
   assign tx_data   = (state_q == SEND || state_q == WAIT_HI || state_q == WAIT_LO) ? byte_out : 8'd0;
   assign x_pos     = x_q;
   assign y_pos     = y_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = pix_q;
`ifdef FRAME_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (busy && abort) begin
         state_d = IDLE;
         idx_d   = 3'd0;
         phase_d = PH_HDR;
         x_d     = 16'd0;
         y_d     = 16'd0;
`ifdef FRAME_CHECKSUM_EN
         sum_d   = 16'd0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start && !abort && !tx_busy) begin
               state_d = HDR;
               idx_d   = 3'd0;
               phase_d = PH_HDR;
               x_d     = 16'd0;
               y_d     = 16'd0;
`ifdef FRAME_CHECKSUM_EN
               sum_d   = 16'd0;
`endif
            end
            HDR: state_d = SEND;
            FETCH: if (pix_valid) begin
               pix_d   = pix_data;
               idx_d   = 3'd0;
               phase_d = PH_PIX;
               state_d = SEND;
            end
            SEND: begin
               state_d = WAIT_HI;
`ifdef FRAME_CHECKSUM_EN
               sum_d   = phase_q == PH_PIX ? sum_q + {8'd0, pix_byte} : sum_q;
`endif
            end
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!tx_busy) begin
               if (phase_q == PH_HDR) begin
                  state_d = idx_q == 3'd4 ? FETCH : HDR;
                  idx_d   = idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1;
               end else if (phase_q == PH_PIX) begin
                  if (!last_ch) begin
                     idx_d   = idx_q + 3'd1;
                     state_d = SEND;
                  end else begin
                     x_d = last_col ? 16'd0 : x_q + 16'd1;
                     y_d = last_pix ? 16'd0 : last_col ? y_q + 16'd1 : y_q;
`ifdef FRAME_CHECKSUM_EN
                     idx_d   = 3'd0;
                     phase_d = last_pix ? PH_TRL : phase_q;
                     state_d = last_pix ? TRAILER : FETCH;
`else
                     state_d = last_pix ? DONE : FETCH;
`endif
                  end
               end else begin
`ifdef FRAME_CHECKSUM_EN
                  state_d = idx_q == 3'd1 ? DONE : TRAILER;
                  idx_d   = idx_q + 3'd1;
`else
                  state_d = DONE;
`endif
               end
            end
`ifdef FRAME_CHECKSUM_EN
            TRAILER: state_d = SEND;
`endif
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         phase_q <= PH_HDR;
         x_q     <= 16'd0;
         y_q     <= 16'd0;
         pix_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
         sum_q   <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pix_q   <= pix_d;
`ifdef FRAME_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
endmodule
